// File: rtl/cordic_cos_iter.sv
// ---------------------------------------------------------------------------
// cordic_cos_iter
// Iterative rotation-mode CORDIC that computes cos(theta). Each enabled clock
// performs one micro-rotation. The angle magnitude comes from the
// float-to-fixed unpacker, and the cosine result goes to the fixed-to-float
// packer. The sign of the angle is dropped upstream because cos is even.
//
// Ports
//   clk_i      rising-edge clock
//   reset_i    asynchronous active-high reset
//   clk_en_i   global enable; when low, all state and outputs are frozen
//   start_i    launch request, sampled only in IDLE while clk_en_i is high
//   theta_i    angle, unsigned Q1.31; values above 1.0 are clamped to 1.0
//   busy_o     high while the engine is in ROTATE or DONE
//   done_o     one-cycle pulse (stretched while clk_en_i is low)
//   result_o   cos(theta), unsigned Q1.31, held until the next completion
// ---------------------------------------------------------------------------
module cordic_cos_iter #(
   parameter int ITER  = 22,
   parameter int GUARD = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_en_i,
   input  logic        start_i,
   input  logic [31:0] theta_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   // Q2.(31+GUARD) signed datapath width
   localparam int W = 34 + GUARD;

   // The atan table is written with 33 fractional bits.
   // Other GUARD values rescale it.
   localparam int LSH = (GUARD >= 2) ? (GUARD - 2) : 0;
   localparam int RSH = (GUARD < 2) ? (2 - GUARD) : 0;

   localparam logic signed [W-1:0] ONE_OUT = {{(W-32){1'b0}}, 32'h8000_0000};
   localparam logic signed [W-1:0] K_INIT  = {{(W-32){1'b0}}, 32'h4DBA_76D4} <<< GUARD;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROTATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // atan(2^-idx) rounded to the nearest value, scaled by 2^33 (Q1.33).
   // Above idx 10, the value rounds to exactly 2^(33-idx).
   function automatic logic signed [W-1:0] atan_lut(input logic [4:0] idx);
      logic signed [63:0] base;
      case (idx)
         5'd0:    base = 64'sd6746518852;
         5'd1:    base = 64'sd3982702635;
         5'd2:    base = 64'sd2104350693;
         5'd3:    base = 64'sd1068201269;
         5'd4:    base = 64'sd536173495;
         5'd5:    base = 64'sd268348126;
         5'd6:    base = 64'sd134206807;
         5'd7:    base = 64'sd67107499;
         5'd8:    base = 64'sd33554261;
         5'd9:    base = 64'sd16777195;
         5'd10:   base = 64'sd8388605;
         default: base = 64'sd1 <<< (6'd33 - {1'b0, idx});
      endcase
      base = (base <<< LSH) >>> RSH;
      return base[W-1:0];
   endfunction

   // Drop the guard bits, then saturate the value into [0, 1.0].
   function automatic logic [31:0] sat_result(input logic signed [W-1:0] x);
      logic signed [W-1:0] t;
      t = x >>> GUARD;
      if (t[W-1]) begin
         return 32'd0;
      end else if (t > ONE_OUT) begin
         return 32'h8000_0000;
      end else begin
         return t[31:0];
      end
   endfunction

   state_t                state_q, state_d;
   logic [4:0]            i_q, i_d;
   logic signed [W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [31:0]           result_q, result_d;

   logic [31:0]           theta_clamp_s;
   logic signed [W-1:0]   x_sh_s, y_sh_s, atan_s;

   // Next-state, datapath, and output logic; when clk_en_i is low, everything holds
   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      x_d           = x_q;
      y_d           = y_q;
      z_d           = z_q;
      busy_d        = busy_q;
      done_d        = done_q;
      result_d      = result_q;
      theta_clamp_s = (theta_i > 32'h8000_0000) ? 32'h8000_0000 : theta_i;
      x_sh_s        = x_q >>> i_q;
      y_sh_s        = y_q >>> i_q;
      atan_s        = atan_lut(i_q);

      if (clk_en_i) begin
         done_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  x_d     = K_INIT;
                  y_d     = '0;
                  z_d     = $signed({{(W-32){1'b0}}, theta_clamp_s}) <<< GUARD;
                  i_d     = 5'd0;
                  state_d = S_ROTATE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ROTATE: begin
               // d = +1 when z >= 0, otherwise -1
               if (!z_q[W-1]) begin
                  x_d = x_q - y_sh_s;
                  y_d = y_q + x_sh_s;
                  z_d = z_q - atan_s;
               end else begin
                  x_d = x_q + y_sh_s;
                  y_d = y_q - x_sh_s;
                  z_d = z_q + atan_s;
               end
               i_d = i_q + 5'd1;
               if (i_q == 5'(ITER - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ROTATE;
               end
            end
            S_DONE: begin
               result_d = sat_result(x_q);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
         busy_d = (state_d != S_IDLE);
      end else begin
         state_d = state_q;
      end
   end

   // State, counter, datapath and output registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         i_q      <= 5'd0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_cordic_cos_iter.sv
// ---------------------------------------------------------------------------
// tb_cordic_cos_iter
// Bench for cordic_cos_iter. The reference model uses real-valued cos(),
// applies the input clamp and the output saturation, and compares results
// within a tolerance. The bench also checks latency, the handshake,
// clock-enable stalls and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_cordic_cos_iter;

   localparam int ITER = 22;
   localparam int TOL  = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [31:0] theta;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   cordic_cos_iter #(.ITER(ITER), .GUARD(2)) dut (
      .clk_i    (clk),
      .reset_i  (reset),
      .clk_en_i (clk_en),
      .start_i  (start),
      .theta_i  (theta),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   always #5 clk = ~clk;

   // round(cos(theta) * 2^31), with theta clamped to 1.0
   function automatic logic [31:0] cos_ref(input logic [31:0] th);
      real    t;
      real    c;
      longint e;
      t = (th > 32'h8000_0000) ? 1.0 : real'(longint'(th)) / 2147483648.0;
      c = $cos(t) * 2147483648.0;
      e = longint'($floor(c + 0.5));
      return e[31:0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      longint diff;
      diff = longint'(obs) - longint'(exp);
      if (diff < 0) diff = -diff;
      checks++;
      assert ((diff <= TOL) && (obs <= 32'h8000_0000) && !$isunknown(obs)) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (+/-%0d)", tag, obs, exp, TOL);
      end
   endtask

   // Count the edges until done rises; the wait is bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Run one operation and return the result and the edges after launch.
   task automatic run_op(input logic [31:0] th, output logic [31:0] res, output int n);
      theta = th;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
      res = result;
   endtask

   initial begin
      logic [31:0] r, r_one, r_half, r_ref, th;
      int          n, n2, cnt;

      reset  = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      theta  = 32'd0;
      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // theta = 0: check latency, saturation and the done pulse
      run_op(32'd0, r, n);
      chk("lat_theta0", 32'(n), 32'(ITER + 1));
      chk_tol("cos0", r, cos_ref(32'd0));
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      tick();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("result_held", result, r);

      // theta = 1.0 and theta = 0.5
      run_op(32'h8000_0000, r_one, n);
      chk("lat_one", 32'(n), 32'(ITER + 1));
      chk_tol("cos1_model", r_one, cos_ref(32'h8000_0000));
      chk_tol("cos1_const", r_one, 32'h4528_A03E);
      run_op(32'h4000_0000, r_half, n);
      chk_tol("cos_half_model", r_half, cos_ref(32'h4000_0000));
      chk_tol("cos_half_const", r_half, 32'h7054_A01A);

      // Inputs above 1.0 are clamped, so the result matches 1.0 exactly
      run_op(32'hFFFF_FFFF, r, n);
      chk("clamp_ffffffff", r, r_one);
      run_op(32'h9000_0000, r, n);
      chk("clamp_90000000", r, r_one);

      // A second start and a theta change mid-run are both ignored
      theta = 32'h4000_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      theta = 32'h1000_0000;
      tick();
      start = 1'b0;
      wait_done(n);
      chk("ignore_lat", 32'(n + 3), 32'(ITER + 1));
      chk("ignore_result", result, r_half);
      cnt = 0;
      for (int k = 0; k < ITER + 4; k++) begin
         tick();
         if (done === 1'b1) cnt++;
      end
      chk("ignore_single_done", 32'(cnt), 32'd0);
      chk("ignore_idle_busy", {31'd0, busy}, 32'd0);

      // clk_en stalls mid-ROTATE and while done is high
      run_op(32'h2AAA_AAAA, r_ref, n);
      chk_tol("cos_2aaa", r_ref, cos_ref(32'h2AAA_AAAA));
      theta = 32'h2AAA_AAAA;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      clk_en = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      clk_en = 1'b1;
      wait_done(n2);
      chk("stall_lat", 32'(n2 + 10), 32'(ITER + 6));
      chk("stall_result", result, r_ref);
      clk_en = 1'b0;
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done === 1'b1) cnt++;
      end
      chk("stretch_done", 32'(cnt), 32'd3);
      clk_en = 1'b1;
      tick();
      chk("stretch_end", {31'd0, done}, 32'd0);

      // Assert an asynchronous reset between edges in mid-ROTATE
      theta = 32'h6000_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      #2;
      reset = 1'b1;
      #1;
      chk("areset_busy", {31'd0, busy}, 32'd0);
      chk("areset_done", {31'd0, done}, 32'd0);
      chk("areset_result", result, 32'd0);
      #1;
      reset = 1'b0;
      tick();
      run_op(32'h6000_0000, r, n);
      chk("post_reset_lat", 32'(n), 32'(ITER + 1));
      chk_tol("post_reset_cos", r, cos_ref(32'h6000_0000));

      // Randomized angles in range, plus some above 1.0
      for (int k = 0; k < 12; k++) begin
         th = $urandom_range(32'h8000_0000);
         run_op(th, r, n);
         chk("rand_lat", 32'(n), 32'(ITER + 1));
         chk_tol("rand_cos", r, cos_ref(th));
      end
      for (int k = 0; k < 3; k++) begin
         th = 32'h8000_0000 | $urandom;
         run_op(th, r, n);
         chk("rand_clamp", r, r_one);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
